// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and line levels.
// The transmitter side of the link uses the same frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Number of data bits in an 8N1 frame.
  localparam int DATA_BITS = 8;

  // Bit index of the stop bit within a frame (0 = start, 1..8 = data).
  localparam int STOP_IDX = 9;

  // Line levels that make up a frame.
  localparam logic IDLE_LEVEL      = 1'b1;
  localparam logic START_BIT_LEVEL = 1'b0;
  localparam logic STOP_BIT_LEVEL  = 1'b1;

  // Two-out-of-three vote used to reject single-sample noise.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high line does not look like a start bit.
module uart_sync #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops give the first one a full cycle to settle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled line, 3-sample majority vote per bit,
// registered byte buffer with ready, framing-error and sticky overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       bclk,
  input  logic       rst,
  input  logic       rx_data,
  input  logic       rx_en,
  input  logic       rx_ack,
  output logic [7:0] RBR,
  output logic       rx_ready,
  output logic       rx_status,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int H     = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);

  localparam logic [CNT_W-1:0] SAMPLE_A = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] SAMPLE_B = CNT_W'(H);
  localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(H + 1);
  localparam logic [CNT_W-1:0] OS_LAST  = CNT_W'(OVERSAMPLE - 1);

  rx_state_t r_state;
  rx_state_t w_nextState;

  logic                 w_rxs;
  logic [CNT_W-1:0]     r_osCnt;
  logic [3:0]           r_bitIdx;
  logic                 r_sampleA;
  logic                 r_sampleB;
  logic [DATA_BITS-1:0] r_shift;

  logic w_decide;
  logic w_wrap;
  logic w_vote;
  logic w_shiftEn;
  logic w_complete;
  logic w_load;
  logic w_overrun;

  uart_sync #(
    .RESET_VALUE(IDLE_LEVEL)
  ) u_sync (
    .i_clk  (bclk),
    .i_rst  (rst),
    .i_async(rx_data),
    .o_sync (w_rxs)
  );

  assign w_decide = (r_osCnt == SAMPLE_C);
  assign w_wrap   = (r_osCnt == OS_LAST);
  assign w_vote   = majority3(r_sampleA, r_sampleB, w_rxs);

  // FSM state register.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; dropping rx_en always abandons the frame in progress.
  always_comb begin
    w_nextState = r_state;
    if (!rx_en) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rxs == START_BIT_LEVEL) begin
            w_nextState = START;
          end
        end
        START: begin
          if (w_decide && w_vote) begin
            w_nextState = IDLE;
          end else if (w_wrap) begin
            w_nextState = DATA;
          end
        end
        DATA: begin
          if (w_wrap && (r_bitIdx == 4'(DATA_BITS))) begin
            w_nextState = STOP;
          end
        end
        STOP: begin
          if (w_decide) begin
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // FSM outputs: when to shift a data bit and whether a finished byte fits.
  always_comb begin
    w_shiftEn  = 1'b0;
    w_complete = 1'b0;
    if (rx_en && w_decide) begin
      w_shiftEn  = (r_state == DATA);
      w_complete = (r_state == STOP) && (r_bitIdx == 4'(STOP_IDX));
    end
    w_load    = w_complete && (!rx_ready || rx_ack);
    w_overrun = w_complete && rx_ready && !rx_ack;
  end

  // Bit-position and bit-index counters; both sit at zero whenever the FSM is idle.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      r_osCnt  <= '0;
      r_bitIdx <= '0;
    end else if ((r_state == IDLE) || (w_nextState == IDLE)) begin
      r_osCnt  <= '0;
      r_bitIdx <= '0;
    end else if (w_wrap) begin
      r_osCnt  <= '0;
      r_bitIdx <= r_bitIdx + 4'd1;
    end else begin
      r_osCnt <= r_osCnt + CNT_W'(1);
    end
  end

  // Capture the two early vote samples; the third is the live line at the decision point.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      r_sampleA <= IDLE_LEVEL;
      r_sampleB <= IDLE_LEVEL;
    end else begin
      if (r_osCnt == SAMPLE_A) begin
        r_sampleA <= w_rxs;
      end
      if (r_osCnt == SAMPLE_B) begin
        r_sampleB <= w_rxs;
      end
    end
  end

  // Data bits arrive LSB first, so shifting in from the MSB side leaves the byte in order.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_shiftEn) begin
      r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
    end
  end

  // Busy flag follows the next state so it changes on the same edge as the FSM.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      rx_status <= 1'b0;
    end else begin
      rx_status <= (w_nextState != IDLE);
    end
  end

  // Receive buffer and framing error only change when a byte is actually accepted.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      RBR       <= '0;
      frame_err <= 1'b0;
    end else if (w_load) begin
      RBR       <= r_shift;
      frame_err <= (w_vote != STOP_BIT_LEVEL);
    end
  end

  // Ready is set by an accepted byte and cleared by an acknowledge; a new byte wins.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      rx_ready <= 1'b0;
    end else if (w_load) begin
      rx_ready <= 1'b1;
    end else if (rx_ack) begin
      rx_ready <= 1'b0;
    end
  end

  // Overrun sticks until acknowledged; a byte arriving with the ack is not an overrun.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      overrun_err <= 1'b0;
    end else if (w_overrun) begin
      overrun_err <= 1'b1;
    end else if (rx_ack) begin
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: directed scenarios plus randomized frames,
// checked every cycle against a line-level behavioural model of the receiver.
module tb_uart_receiver;

  localparam int OS = 16;
  localparam int H  = OS / 2;

  logic       bclk = 1'b0;
  logic       rst;
  logic       rx_data;
  logic       rx_en;
  logic       rx_ack;
  logic [7:0] RBR;
  logic       rx_ready;
  logic       rx_status;
  logic       frame_err;
  logic       overrun_err;

  uart_receiver #(
    .OVERSAMPLE(OS)
  ) dut (
    .bclk       (bclk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_en      (rx_en),
    .rx_ack     (rx_ack),
    .RBR        (RBR),
    .rx_ready   (rx_ready),
    .rx_status  (rx_status),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 bclk = ~bclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Line level seen at each bclk edge, indexed by edge number.
  bit lineAt [0:131071];

  // Model state: what the receiver outputs must be, derived from frame timing rules.
  logic [7:0] mRBR;
  logic       mReady, mFerr, mOver, mStatus;
  bit         mActive;
  int         mStart;
  logic [7:0] mBits;

  // Scratch for the model step.
  logic sAck, sEn;
  bit   comp;
  logic cv, v;
  int   rel, k, base;

  // Edge bookkeeping for latency checks.
  logic prevReady = 1'b0, prevStatus = 1'b0, prevMReady = 1'b0, prevMStatus = 1'b0;
  int   readyRiseEdge = -1, statusFallEdge = -1, mReadyRiseEdge = -1, mStatusFallEdge = -1;

  bit ackRandom = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a + b + c) >= 2;
  endfunction

  // Model step and per-cycle comparison, just after each rising edge.
  always begin : compareProc
    @(posedge bclk);
    cyc++;
    lineAt[cyc] = rx_data;
    sAck = rx_ack;
    sEn  = rx_en;
    #1;
    if (rst) begin
      mRBR = 8'h00; mReady = 0; mFerr = 0; mOver = 0; mStatus = 0;
      mActive = 0; mBits = 8'h00;
      // The synchronizer is preset to idle, so the line it reports stays high.
      lineAt[cyc] = 1'b1;
      lineAt[cyc-1] = 1'b1;
    end else begin
      comp = 0;
      cv   = 1'b1;
      if (mActive && !sEn) begin
        mActive = 0;
      end else if (mActive) begin
        rel = cyc - mStart;
        if (rel >= H + 2 && ((rel - H - 2) % OS) == 0) begin
          k    = (rel - H - 2) / OS;
          base = mStart - 1 + k * OS + H - 1;
          v    = maj3(lineAt[base], lineAt[base+1], lineAt[base+2]);
          if (k == 0) begin
            if (v) mActive = 0;
          end else if (k <= 8) begin
            mBits[k-1] = v;
          end else begin
            comp    = 1;
            cv      = v;
            mActive = 0;
          end
        end
      end else if (sEn && cyc >= 2 && lineAt[cyc-2] == 1'b0) begin
        mActive = 1;
        mStart  = cyc;
      end
      if (comp) begin
        if (!mReady || sAck) begin
          mRBR   = mBits;
          mReady = 1;
          mFerr  = !cv;
          if (sAck) mOver = 0;
        end else begin
          mOver = 1;
        end
      end else if (sAck) begin
        mReady = 0;
        mOver  = 0;
      end
      mStatus = mActive;
    end
    checkOutput("RBR", RBR, mRBR);
    checkOutput("rx_ready", rx_ready, mReady);
    checkOutput("rx_status", rx_status, mStatus);
    checkOutput("frame_err", frame_err, mFerr);
    checkOutput("overrun_err", overrun_err, mOver);
    if (rx_ready === 1'b1 && prevReady !== 1'b1) readyRiseEdge = cyc;
    if (rx_status === 1'b0 && prevStatus === 1'b1) statusFallEdge = cyc;
    if (mReady && !prevMReady) mReadyRiseEdge = cyc;
    if (!mStatus && prevMStatus) mStatusFallEdge = cyc;
    prevReady   = rx_ready;
    prevStatus  = rx_status;
    prevMReady  = mReady;
    prevMStatus = mStatus;
  end

  task automatic driveAck();
    rx_ack = ackRandom ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge bclk);
      rx_data = 1'b1;
      driveAck();
    end
  endtask

  task automatic doAck();
    @(negedge bclk);
    rx_ack = 1'b1;
    @(negedge bclk);
    rx_ack = 1'b0;
  endtask

  // Send one frame; optional single-cycle glitch, optional abort (0 = rst, 1 = rx_en low).
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int glitchBit,
                               input int glitchOff, input int abortBit, input int abortKind,
                               output int startEdge);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    startEdge = -1;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < OS; c++) begin
        @(negedge bclk);
        if (i == abortBit && c == 0) begin
          rx_data = 1'b1;
          if (abortKind == 0) begin
            rst = 1'b1;
            @(negedge bclk);
            rst = 1'b0;
          end else begin
            rx_en = 1'b0;
            repeat (OS * 11) @(negedge bclk);
            rx_en = 1'b1;
          end
          return;
        end
        rx_data = frame[i] ^ ((i == glitchBit) && (c == glitchOff));
        driveAck();
        if (i == 0 && c == 0) startEdge = cyc + 1;
      end
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int s;
    int g;
    logic [7:0] rb;
    logic       rs;
    int         gb, go;

    rst = 1'b1; rx_data = 1'b1; rx_en = 1'b1; rx_ack = 1'b0;
    repeat (3) @(negedge bclk);
    rst = 1'b0;
    @(posedge bclk); #2;
    checkOutput("reset_rbr", RBR, 8'h00);
    checkOutput("reset_ready", rx_ready, 0);
    checkOutput("reset_status", rx_status, 0);
    checkOutput("reset_flags", {frame_err, overrun_err}, 2'b00);
    idleCycles(10);

    $display("[TB] clean frame 0xA5");
    applyStimulus(8'hA5, 1'b1, -1, 0, -1, 0, s);
    idleCycles(20);
    checkOutput("a5_rbr", RBR, 8'hA5);
    checkOutput("a5_flags", {rx_ready, frame_err, overrun_err}, 3'b100);
    checkOutput("a5_ready_latency", readyRiseEdge - s, 156);
    checkOutput("a5_model_rbr", mRBR, 8'hA5);
    checkOutput("a5_model_latency", mReadyRiseEdge - s, 156);
    doAck();
    idleCycles(5);

    $display("[TB] idle glitch of 3 cycles");
    @(negedge bclk);
    g = cyc + 1;
    rx_data = 1'b0;
    repeat (2) begin @(negedge bclk); rx_data = 1'b0; end
    idleCycles(30);
    checkOutput("glitch_status_fall", statusFallEdge - g, 12);
    checkOutput("glitch_model_fall", mStatusFallEdge - g, 12);
    checkOutput("glitch_ready", rx_ready, 0);
    checkOutput("glitch_rbr", RBR, 8'hA5);

    $display("[TB] framing error 0x3C then 0x55");
    applyStimulus(8'h3C, 1'b0, -1, 0, -1, 0, s);
    idleCycles(40);
    checkOutput("ferr_rbr", RBR, 8'h3C);
    checkOutput("ferr_flags", {rx_ready, frame_err}, 2'b11);
    doAck();
    applyStimulus(8'h55, 1'b1, -1, 0, -1, 0, s);
    idleCycles(20);
    checkOutput("ferr_clear_rbr", RBR, 8'h55);
    checkOutput("ferr_clear_flag", frame_err, 0);
    doAck();

    $display("[TB] overrun 0x11 0x22");
    applyStimulus(8'h11, 1'b1, -1, 0, -1, 0, s);
    applyStimulus(8'h22, 1'b1, -1, 0, -1, 0, s);
    idleCycles(20);
    checkOutput("ovr_rbr", RBR, 8'h11);
    checkOutput("ovr_flags", {rx_ready, overrun_err}, 2'b11);
    doAck();
    idleCycles(2);
    checkOutput("ovr_ack_flags", {rx_ready, overrun_err}, 2'b00);
    applyStimulus(8'h33, 1'b1, -1, 0, -1, 0, s);
    idleCycles(20);
    checkOutput("ovr_next_rbr", RBR, 8'h33);
    doAck();

    $display("[TB] mid-bit glitch 0x81");
    applyStimulus(8'h81, 1'b1, 4, H + 1, -1, 0, s);
    idleCycles(20);
    checkOutput("vote_rbr", RBR, 8'h81);
    doAck();

    $display("[TB] reset mid-frame");
    applyStimulus(8'hF0, 1'b1, -1, 0, 3, 0, s);
    @(posedge bclk); #2;
    checkOutput("rst_outputs", {RBR, rx_ready, rx_status, frame_err, overrun_err}, 12'h000);
    idleCycles(10);
    applyStimulus(8'h0F, 1'b1, -1, 0, -1, 0, s);
    idleCycles(20);
    checkOutput("rst_next_rbr", RBR, 8'h0F);
    checkOutput("rst_next_flags", {rx_ready, frame_err, overrun_err}, 3'b100);
    doAck();

    $display("[TB] rx_en dropped mid-frame");
    idleCycles(5);
    applyStimulus(8'hF0, 1'b1, -1, 0, 3, 1, s);
    idleCycles(10);
    checkOutput("en_rbr", RBR, 8'h0F);
    checkOutput("en_flags", {rx_ready, rx_status, frame_err, overrun_err}, 4'b0000);
    applyStimulus(8'h5A, 1'b1, -1, 0, -1, 0, s);
    idleCycles(20);
    checkOutput("en_next_rbr", RBR, 8'h5A);
    doAck();

    $display("[TB] randomized frames");
    ackRandom = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) begin
        gb = $urandom_range(1, 8);
        go = $urandom_range(0, OS - 1);
      end else begin
        gb = -1;
        go = 0;
      end
      applyStimulus(rb, rs, gb, go, -1, 0, s);
      idleCycles($urandom_range(0, 30));
    end
    ackRandom = 1'b0;
    idleCycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
